// File: rtl/rc4_ksg_if.sv
// Request/response bundle between the key-derivation stage and the RC4 keystream generator.
// The master drives the job request; the slave (rc4_ksg) returns status and keystream.
interface rc4_ksg_if #(
  parameter int unsigned KEY_BYTES = 5,
  parameter int unsigned OUT_BYTES = 16
) ();
  logic                   start;
  logic                   abort;
  logic [8*KEY_BYTES-1:0] key;
  logic [4:0]             key_len;
  logic                   busy;
  logic                   ks_valid;
  logic [7:0]             ks_byte;
  logic                   done;
  logic [8*OUT_BYTES-1:0] keystream;

  modport master (
    output start, abort, key, key_len,
    input  busy, ks_valid, ks_byte, done, keystream
  );

  modport slave (
    input  start, abort, key, key_len,
    output busy, ks_valid, ks_byte, done, keystream
  );
endinterface

// File: rtl/rc4_ksg.sv
// RC4 keystream generator: one KSA iteration or one PRGA byte per cycle on a register-array
// S-box. An optional prefix of PRGA bytes is discarded before OUT_BYTES bytes are delivered,
// both as a per-byte strobe stream and as a parallel word held until the next accepted start.
module rc4_ksg #(
  parameter int unsigned KEY_BYTES = 5,
  parameter int unsigned OUT_BYTES = 16,
  parameter int unsigned DROP      = 0
) (
  input logic      clk,
  input logic      rst_n,
  rc4_ksg_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StInit, StKsa, StPrga, StDone} state_e;

  state_e r_state;
  state_e w_state_next;

  // S-box contents are don't-care out of reset, so the array carries no reset.
  logic [7:0]             r_sbox [256];
  logic [127:0]           r_key;
  logic [4:0]             r_len;
  logic [3:0]             r_kidx;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [10:0]            r_drop;
  logic [5:0]             r_slot;
  logic                   r_ks_valid;
  logic [7:0]             r_ks_byte;
  logic [8*OUT_BYTES-1:0] r_ks;

  logic [127:0] w_key_pad;
  logic [4:0]   w_len_eff;
  logic [7:0]   w_kbyte;
  logic [7:0]   w_ia;
  logic [7:0]   w_si;
  logic [7:0]   w_jn;
  logic [7:0]   w_sj;
  logic [7:0]   w_t;
  logic [7:0]   w_st;
  logic [7:0]   w_out;
  logic         w_ksa_last;
  logic         w_prga_last;
  logic         w_run;

  // Shared KSA/PRGA datapath: index selection, S-box reads and output-byte forwarding.
  always_comb begin
    w_key_pad   = 128'(bus.key);
    w_len_eff   = (bus.key_len == 5'd0 || bus.key_len > 5'(KEY_BYTES)) ? 5'(KEY_BYTES)
                                                                       : bus.key_len;
    w_kbyte     = r_key[{r_kidx, 3'b000} +: 8];
    w_ia        = (r_state == StPrga) ? r_i + 8'd1 : r_i;
    w_si        = r_sbox[w_ia];
    w_jn        = r_j + w_si + ((r_state == StKsa) ? w_kbyte : 8'd0);
    w_sj        = r_sbox[w_jn];
    w_t         = w_si + w_sj;
    w_st        = r_sbox[w_t];
    // S[t] is read pre-swap; forward the swapped values when t hits a swapped slot.
    if (w_t == w_ia) begin
      w_out = w_sj;
    end else if (w_t == w_jn) begin
      w_out = w_si;
    end else begin
      w_out = w_st;
    end
    w_ksa_last  = (r_i == 8'hff);
    w_prga_last = (r_drop == 11'd0) && (r_slot == 6'(OUT_BYTES - 1));
    w_run       = (r_state == StKsa) || (r_state == StPrga);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; abort wins over every forward transition while busy.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (bus.start) w_state_next = StInit;
      StInit: w_state_next = bus.abort ? StIdle : StKsa;
      StKsa: begin
        if (bus.abort) begin
          w_state_next = StIdle;
        end else if (w_ksa_last) begin
          w_state_next = StPrga;
        end
      end
      StPrga: begin
        if (bus.abort) begin
          w_state_next = StIdle;
        end else if (w_prga_last) begin
          w_state_next = StDone;
        end
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // S-box: identity load in INIT, one swap per KSA/PRGA cycle. Equal indices write the same
  // value twice, so the entry is unchanged.
  always_ff @(posedge clk) begin
    if (r_state == StInit) begin
      for (int k = 0; k < 256; k++) begin
        r_sbox[k] <= 8'(k);
      end
    end else if (w_run && !bus.abort) begin
      r_sbox[w_ia] <= w_sj;
      r_sbox[w_jn] <= w_si;
    end
  end

  // Job registers, index counters and keystream delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key      <= '0;
      r_len      <= '0;
      r_kidx     <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_drop     <= '0;
      r_slot     <= '0;
      r_ks_valid <= 1'b0;
      r_ks_byte  <= '0;
      r_ks       <= '0;
    end else begin
      r_ks_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_key <= w_key_pad;
            r_len <= w_len_eff;
            r_ks  <= '0;
          end
        end
        StInit: begin
          r_i    <= '0;
          r_j    <= '0;
          r_kidx <= '0;
          r_drop <= 11'(DROP);
          r_slot <= '0;
        end
        StKsa: begin
          // i wraps 255 -> 0 naturally; j is forced to 0 for the PRGA hand-off.
          r_i    <= r_i + 8'd1;
          r_j    <= w_ksa_last ? 8'd0 : w_jn;
          r_kidx <= ({1'b0, r_kidx} == r_len - 5'd1) ? 4'd0 : r_kidx + 4'd1;
        end
        StPrga: begin
          if (!bus.abort) begin
            r_i <= w_ia;
            r_j <= w_jn;
            if (r_drop != 11'd0) begin
              r_drop <= r_drop - 11'd1;
            end else begin
              r_ks_valid <= 1'b1;
              r_ks_byte  <= w_out;
              r_slot     <= r_slot + 6'd1;
              for (int k = 0; k < int'(OUT_BYTES); k++) begin
                if (r_slot == 6'(k)) r_ks[8*k +: 8] <= w_out;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state == StInit) || w_run;
  assign bus.done      = (r_state == StDone);
  assign bus.ks_valid  = r_ks_valid;
  assign bus.ks_byte   = r_ks_byte;
  assign bus.keystream = r_ks;

endmodule

// File: tb/tb_rc4_ksg.sv
// Bench for rc4_ksg: three instances (40-bit key, 128-bit key with 32 output bytes, and a
// 16-byte drop variant) checked against a plain-arithmetic RC4 reference.
module tb_rc4_ksg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rc4_ksg_if #(.KEY_BYTES(5),  .OUT_BYTES(16)) b0 ();
  rc4_ksg_if #(.KEY_BYTES(16), .OUT_BYTES(32)) b1 ();
  rc4_ksg_if #(.KEY_BYTES(16), .OUT_BYTES(16)) b2 ();

  rc4_ksg #(.KEY_BYTES(5),  .OUT_BYTES(16), .DROP(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  rc4_ksg #(.KEY_BYTES(16), .OUT_BYTES(32), .DROP(0))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  rc4_ksg #(.KEY_BYTES(16), .OUT_BYTES(16), .DROP(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic         start_v [3];
  logic         abort_v [3];
  logic [127:0] key_v   [3];
  logic [4:0]   len_v   [3];
  logic [255:0] ks_o    [3];
  logic         done_o  [3];
  logic         busy_o  [3];
  logic         valid_o [3];
  logic [7:0]   byte_o  [3];

  assign b0.start = start_v[0];
  assign b1.start = start_v[1];
  assign b2.start = start_v[2];
  assign b0.abort = abort_v[0];
  assign b1.abort = abort_v[1];
  assign b2.abort = abort_v[2];
  assign b0.key = key_v[0][39:0];
  assign b1.key = key_v[1];
  assign b2.key = key_v[2];
  assign b0.key_len = len_v[0];
  assign b1.key_len = len_v[1];
  assign b2.key_len = len_v[2];
  assign ks_o[0] = 256'(b0.keystream);
  assign ks_o[1] = b1.keystream;
  assign ks_o[2] = 256'(b2.keystream);
  assign done_o[0] = b0.done;
  assign done_o[1] = b1.done;
  assign done_o[2] = b2.done;
  assign busy_o[0] = b0.busy;
  assign busy_o[1] = b1.busy;
  assign busy_o[2] = b2.busy;
  assign valid_o[0] = b0.ks_valid;
  assign valid_o[1] = b1.ks_valid;
  assign valid_o[2] = b2.ks_valid;
  assign byte_o[0] = b0.ks_byte;
  assign byte_o[1] = b1.ks_byte;
  assign byte_o[2] = b2.ks_byte;

  // Textbook RC4: returns n bytes after discarding drop, byte k at [8k+:8].
  function automatic logic [255:0] rc4_ref(input logic [127:0] key, input int len,
                                           input int drop, input int n);
    int s [256];
    int i, j, t, tmp;
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(key[8*(x % len) +: 8])) % 256;
      tmp = s[x]; s[x] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int c = 0; c < drop + n; c++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = (s[i] + s[j]) % 256;
      if (c >= drop) r[8*(c-drop) +: 8] = 8'(s[t]);
    end
    return r;
  endfunction

  function automatic int eff_len(input int len, input int kb);
    return (len == 0 || len > kb) ? kb : len;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on every instance selected in mask, then scramble the key inputs.
  task automatic launch(input bit [2:0] mask, input logic [127:0] key, input logic [4:0] len);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      if (mask[w]) begin
        key_v[w] = key;
        len_v[w] = len;
        start_v[w] = 1'b1;
      end
    end
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      if (mask[w]) begin
        start_v[w] = 1'b0;
        key_v[w] = {$urandom(), $urandom(), $urandom(), $urandom()};
        len_v[w] = 5'($urandom_range(0, 31));
      end
    end
  endtask

  // Wait (bounded) for done; optionally re-pulse start with another key at cycle poke_at.
  task automatic wait_done(input int which, input int poke_at, input logic [127:0] poke_key,
                           output int cycles, output int nvalid, output logic [255:0] stream);
    cycles = 0;
    nvalid = 0;
    stream = '0;
    while (cycles < 2000) begin
      @(negedge clk);
      cycles++;
      start_v[which] = (cycles == poke_at);
      if (cycles == poke_at) key_v[which] = poke_key;
      if (valid_o[which]) begin
        if (nvalid < 32) stream[8*nvalid +: 8] = byte_o[which];
        nvalid++;
      end
      if (done_o[which]) break;
    end
    start_v[which] = 1'b0;
    check("done_seen", 256'(done_o[which]), 256'(1));
  endtask

  initial begin
    int cyc, nv, len, hits;
    logic [255:0] st, exp;
    logic [127:0] k, k2;

    for (int w = 0; w < 3; w++) begin
      start_v[w] = 1'b0;
      abort_v[w] = 1'b0;
      key_v[w] = '0;
      len_v[w] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("rst_busy", 256'(busy_o[0]), 256'(0));
    check("rst_done", 256'(done_o[0]), 256'(0));
    check("rst_valid", 256'(valid_o[0]), 256'(0));
    check("rst_byte", 256'(byte_o[0]), 256'(0));
    check("rst_ks0", ks_o[0], 256'(0));
    check("rst_ks1", ks_o[1], 256'(0));

    // Known-answer 40-bit key, latency and byte stream.
    launch(3'b001, 128'h0504030201, 5'd5);
    wait_done(0, -1, '0, cyc, nv, st);
    check("t1_latency", 256'(cyc), 256'(273));
    check("t1_keystream", ks_o[0], 256'(128'ha818110a4a52c3cc27c03df0056339b2));
    check("t1_stream", st, 256'(128'ha818110a4a52c3cc27c03df0056339b2));
    check("t1_nvalid", 256'(nv), 256'(16));
    @(negedge clk);
    check("t1_done_pulse", 256'(done_o[0]), 256'(0));
    check("t1_busy_after", 256'(busy_o[0]), 256'(0));

    // Known-answer "Key" and "Wiki" with a 16-byte key port.
    launch(3'b010, 128'h79654b, 5'd3);
    wait_done(1, -1, '0, cyc, nv, st);
    check("t2_latency", 256'(cyc), 256'(289));
    check("t2_key", 256'(ks_o[1][79:0]), 256'(80'h19a772ca34b781779feb));
    launch(3'b010, 128'h696b6957, 5'd4);
    wait_done(1, -1, '0, cyc, nv, st);
    check("t2_wiki", 256'(ks_o[1][47:0]), 256'(48'hb7416ddb4460));
    check("t2_wiki_nvalid", 256'(nv), 256'(32));

    // Random keys and lengths, including 0 and out-of-range key_len.
    for (int r = 0; r < 4; r++) begin
      k = 128'({$urandom(), $urandom()});
      len = (r == 0) ? 0 : (r == 1) ? 7 : int'($urandom_range(1, 5));
      launch(3'b001, k, 5'(len));
      wait_done(0, -1, '0, cyc, nv, st);
      exp = rc4_ref(k & 128'hff_ffff_ffff, eff_len(len, 5), 0, 16);
      check("rand0_ks", ks_o[0], exp);
      check("rand0_stream", st, exp);
    end
    for (int r = 0; r < 3; r++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      len = (r == 0) ? 0 : (r == 1) ? 20 : int'($urandom_range(1, 16));
      launch(3'b010, k, 5'(len));
      wait_done(1, -1, '0, cyc, nv, st);
      check("rand1_ks", ks_o[1], rc4_ref(k, eff_len(len, 16), 0, 32));
    end

    // Drop prefix: the DROP=16 instance equals bytes 16..31 of a plain run.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(3'b110, k, 5'd16);
    wait_done(2, -1, '0, cyc, nv, st);
    check("t3_latency", 256'(cyc), 256'(289));
    check("t3_nvalid", 256'(nv), 256'(16));
    check("t3_ref_done", 256'(done_o[1]), 256'(1));
    check("t3_drop_ks", ks_o[2], rc4_ref(k, 16, 16, 16));
    check("t3_drop_stream", st, rc4_ref(k, 16, 16, 16));
    check("t3_full_ks", ks_o[1], rc4_ref(k, 16, 0, 32));
    check("t3_upper_half", ks_o[2], ks_o[1] >> 128);

    // Abort 100 cycles into KSA, then the known-answer run again.
    launch(3'b001, 128'({$urandom(), $urandom()}), 5'd5);
    repeat (100) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("t4_busy_off", 256'(busy_o[0]), 256'(0));
    hits = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_o[0] || valid_o[0]) hits++;
    end
    check("t4_no_done", 256'(hits), 256'(0));
    check("t4_ks_cleared", ks_o[0], 256'(0));
    launch(3'b001, 128'h0504030201, 5'd5);
    wait_done(0, -1, '0, cyc, nv, st);
    check("t4_rerun", ks_o[0], 256'(128'ha818110a4a52c3cc27c03df0056339b2));

    // Abort in PRGA after five delivered bytes keeps the partial keystream.
    k = 128'({$urandom(), $urandom()});
    launch(3'b001, k, 5'd5);
    repeat (262) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("t4b_valid_blocked", 256'(valid_o[0]), 256'(0));
    check("t4b_busy_off", 256'(busy_o[0]), 256'(0));
    exp = rc4_ref(k & 128'hff_ffff_ffff, 5, 0, 16) & 256'h00ff_ffff_ffff;
    check("t4b_partial", ks_o[0], exp);

    // start during PRGA with a different key is ignored.
    k = 128'({$urandom(), $urandom()});
    k2 = ~k;
    launch(3'b001, k, 5'd5);
    wait_done(0, 265, k2, cyc, nv, st);
    check("t5_latency", 256'(cyc), 256'(273));
    check("t5_ks", ks_o[0], rc4_ref(k & 128'hff_ffff_ffff, 5, 0, 16));
    @(negedge clk);
    @(negedge clk);
    check("t5_not_queued", 256'(busy_o[0]), 256'(0));

    // Asynchronous reset mid-PRGA clears outputs immediately.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(3'b010, k, 5'd16);
    repeat (265) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 256'(busy_o[1]), 256'(0));
    check("t6_valid", 256'(valid_o[1]), 256'(0));
    check("t6_byte", 256'(byte_o[1]), 256'(0));
    check("t6_done", 256'(done_o[1]), 256'(0));
    check("t6_ks", ks_o[1], 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(3'b010, k, 5'd9);
    wait_done(1, -1, '0, cyc, nv, st);
    check("t6_rerun", ks_o[1], rc4_ref(k, 9, 0, 32));
    check("t6_stream", st, rc4_ref(k, 9, 0, 32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
